ppu_reg_responder: RTL and testbench

CPU-bus responder for the eight PPU registers at $2000-$2007, mirrored every 8 bytes through $3FFF. It sits on the same addr/dataWr/wrEn bus the RP2A03 core drives and returns read data on dataRd. It holds the programmer-visible PPU state: PPUCTRL, PPUMASK, status flags, OAMADDR, the scroll/address latches (v, t, fineX, write toggle w) and the PPUDATA read buffer. It drives OAM and VRAM access ports and exports the render-control state and NMI request to the PPU core.

---
 rtl/ppu_reg_responder.sv | 179 +++++++++++++++++
 tb/tb_ppu_reg_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_reg_responder.sv
// ppu_reg_responder: CPU-side register file for the PPU at $2000-$2007
// (mirrored through $3FFF). Holds PPUCTRL/PPUMASK, status flags, OAMADDR,
// the v/t/fineX/w scroll latches and the PPUDATA read buffer, and drives
// the OAM and VRAM access ports.

module ppu_reg_responder #(
    parameter int VRAM_RD_LATENCY = 1
) (
    input  logic        cpuClk,
    input  logic        reset,
    input  logic        sel,
    input  logic [2:0]  addr,
    input  logic [7:0]  dataWr,
    input  logic        wrEn,
    output logic [7:0]  dataRd,
    input  logic        vblankSet,
    input  logic        vblankClr,
    input  logic        sprite0HitSet,
    input  logic        spriteOvfSet,
    output logic        nmi,
    output logic [7:0]  ctrl,
    output logic [7:0]  mask,
    output logic [14:0] v,
    output logic [14:0] t,
    output logic [2:0]  fineX,
    output logic [7:0]  oamAddr,
    output logic [7:0]  oamWrData,
    output logic        oamWr,
    input  logic [7:0]  oamRdData,
    output logic [13:0] vramAddr,
    output logic [7:0]  vramWrData,
    output logic        vramWr,
    output logic        vramRd,
    input  logic [7:0]  vramRdData
);

    // The fill FSM captures read data exactly one cycle after vramRd.
    if (VRAM_RD_LATENCY != 1) begin : gBadLatency
        $error("ppu_reg_responder supports only VRAM_RD_LATENCY = 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fillState_t;

    fillState_t  fillState;
    logic [7:0]  openBus;
    logic [7:0]  readBuf;
    logic        w;
    logic        vblank;
    logic        sprite0Hit;
    logic        spriteOvf;

    logic        busWr;
    logic        busRd;
    logic        statusRead;
    logic        dataRead;
    logic [14:0] vInc;

    assign busWr      = sel & wrEn;
    assign busRd      = sel & ~wrEn;
    assign statusRead = busRd && (addr == 3'd2);
    assign dataRead   = busRd && (addr == 3'd7);
    assign vInc       = ctrl[2] ? 15'd32 : 15'd1;

    // Access-cycle strobes go straight out with the bus cycle.
    assign oamWr      = busWr && (addr == 3'd4);
    assign oamWrData  = dataWr;
    assign vramWr     = busWr && (addr == 3'd7);
    assign vramRd     = dataRead;
    assign vramWrData = dataWr;
    assign vramAddr   = v[13:0];
    assign nmi        = vblank & ctrl[7];

    // Read mux: everything not explicitly readable floats to the open-bus latch.
    always_comb begin
        // NOTE: default assignment first so no path leaves dataRd unassigned (no latch).
        dataRd = openBus;
        if (busRd) begin
            case (addr)
                3'd2:    dataRd = {vblank, sprite0Hit, spriteOvf, openBus[4:0]};
                3'd4:    dataRd = oamRdData;
                3'd7:    dataRd = readBuf;
                default: dataRd = openBus;
            endcase
        end
    end

    // Programmer-visible registers and the scroll/address latches.
    always_ff @(posedge cpuClk or negedge reset) begin
        if (!reset) begin
            ctrl    <= 8'h00;
            mask    <= 8'h00;
            oamAddr <= 8'h00;
            openBus <= 8'h00;
            v       <= 15'h0000;
            t       <= 15'h0000;
            fineX   <= 3'd0;
            w       <= 1'b0;
        end else if (sel) begin
            if (wrEn) begin
                // NOTE: non-blocking so the $2006 second write copies the pre-edge t[14:8] into v.
                openBus <= dataWr;
                case (addr)
                    3'd0: begin
                        ctrl     <= dataWr;
                        t[11:10] <= dataWr[1:0];
                    end
                    3'd1: mask    <= dataWr;
                    3'd3: oamAddr <= dataWr;
                    3'd4: oamAddr <= oamAddr + 8'd1;
                    3'd5: begin
                        if (!w) begin
                            t[4:0] <= dataWr[7:3];
                            fineX  <= dataWr[2:0];
                            w      <= 1'b1;
                        end else begin
                            t[14:12] <= dataWr[2:0];
                            t[9:5]   <= dataWr[7:3];
                            w        <= 1'b0;
                        end
                    end
                    3'd6: begin
                        if (!w) begin
                            t[13:8] <= dataWr[5:0];
                            t[14]   <= 1'b0;
                            w       <= 1'b1;
                        end else begin
                            t[7:0] <= dataWr;
                            v      <= {t[14:8], dataWr};
                            w      <= 1'b0;
                        end
                    end
                    3'd7:    v <= v + vInc;
                    default: ;
                endcase
            end else begin
                case (addr)
                    3'd2:    w <= 1'b0;
                    3'd7:    v <= v + vInc;
                    default: ;
                endcase
            end
        end
    end

    // Status flags: set pulse beats pre-render clear beats the $2002 read clear.
    always_ff @(posedge cpuClk or negedge reset) begin
        if (!reset) begin
            vblank     <= 1'b0;
            sprite0Hit <= 1'b0;
            spriteOvf  <= 1'b0;
        end else begin
            if (vblankSet)       vblank <= 1'b1;
            else if (vblankClr)  vblank <= 1'b0;
            else if (statusRead) vblank <= 1'b0;

            if (sprite0HitSet)   sprite0Hit <= 1'b1;
            else if (vblankClr)  sprite0Hit <= 1'b0;

            if (spriteOvfSet)    spriteOvf <= 1'b1;
            else if (vblankClr)  spriteOvf <= 1'b0;
        end
    end

    // PPUDATA read-buffer fill: a $2007 read enters FILL, FILL captures the
    // BRAM output and leaves unless another read re-arms it the same cycle.
    always_ff @(posedge cpuClk or negedge reset) begin
        if (!reset) begin
            fillState <= IDLE;
            readBuf   <= 8'h00;
        end else begin
            if (fillState == FILL) readBuf <= vramRdData;
            fillState <= dataRead ? FILL : IDLE;
        end
    end

endmodule

// File: tb/tb_ppu_reg_responder.sv
// tb_ppu_reg_responder: directed checks of the documented scenarios followed
// by randomized bus traffic compared against a transaction-level model.

module tb_ppu_reg_responder;

    logic        cpuClk = 1'b0;
    logic        reset  = 1'b0;
    logic        sel = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [7:0]  dataWr = 8'h00;
    logic        wrEn = 1'b0;
    logic [7:0]  dataRd;
    logic        vblankSet = 1'b0;
    logic        vblankClr = 1'b0;
    logic        sprite0HitSet = 1'b0;
    logic        spriteOvfSet = 1'b0;
    logic        nmi;
    logic [7:0]  ctrl;
    logic [7:0]  mask;
    logic [14:0] v;
    logic [14:0] t;
    logic [2:0]  fineX;
    logic [7:0]  oamAddr;
    logic [7:0]  oamWrData;
    logic        oamWr;
    logic [7:0]  oamRdData;
    logic [13:0] vramAddr;
    logic [7:0]  vramWrData;
    logic        vramWr;
    logic        vramRd;
    logic [7:0]  vramRdData = 8'h00;

    ppu_reg_responder #(.VRAM_RD_LATENCY(1)) dut (
        .cpuClk(cpuClk), .reset(reset), .sel(sel), .addr(addr),
        .dataWr(dataWr), .wrEn(wrEn), .dataRd(dataRd),
        .vblankSet(vblankSet), .vblankClr(vblankClr),
        .sprite0HitSet(sprite0HitSet), .spriteOvfSet(spriteOvfSet),
        .nmi(nmi), .ctrl(ctrl), .mask(mask), .v(v), .t(t), .fineX(fineX),
        .oamAddr(oamAddr), .oamWrData(oamWrData), .oamWr(oamWr),
        .oamRdData(oamRdData), .vramAddr(vramAddr), .vramWrData(vramWrData),
        .vramWr(vramWr), .vramRd(vramRd), .vramRdData(vramRdData)
    );

    always #5 cpuClk = ~cpuClk;

    // Environment: synchronous VRAM and combinational OAM driven by the DUT ports.
    logic [7:0] envVram [0:16383];
    logic [7:0] envOam  [0:255];

    always @(posedge cpuClk) begin
        if (vramWr) envVram[vramAddr] <= vramWrData;
        if (vramRd) vramRdData <= envVram[vramAddr];
        if (oamWr)  envOam[oamAddr] <= oamWrData;
    end
    assign oamRdData = envOam[oamAddr];

    // Reference model state.
    logic [7:0]  mVram [0:16383];
    logic [7:0]  mOam  [0:255];
    logic [7:0]  mCtrl, mMask, mOamAddr, mOpen, mBuf, mPendData;
    logic [14:0] mV, mT;
    logic [2:0]  mFx;
    logic        mW, mVbl, mS0, mOvf, mPend;

    int nTests = 0;
    int nFail  = 0;

    logic [7:0]  lastRd, lastOamAddr, lastOamData, lastVramData;
    logic [13:0] lastVramAddr;
    logic        lastOamWr, lastVramWr, lastVramRd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mCtrl = 8'h00; mMask = 8'h00; mOamAddr = 8'h00; mOpen = 8'h00;
        mBuf = 8'h00; mPendData = 8'h00; mV = 15'h0; mT = 15'h0; mFx = 3'd0;
        mW = 1'b0; mVbl = 1'b0; mS0 = 1'b0; mOvf = 1'b0; mPend = 1'b0;
    endtask

    // One bus cycle of register semantics, applied at the clock edge.
    task automatic modelStep(input logic s, input logic wr, input logic [2:0] a,
                             input logic [7:0] d, input logic vs, input logic vc,
                             input logic s0s, input logic os);
        logic [14:0] inc;
        logic statusRd;
        inc = mCtrl[2] ? 15'd32 : 15'd1;
        statusRd = s && !wr && (a == 3'd2);
        // The fill armed by last cycle's PPUDATA read lands now.
        if (mPend) mBuf = mPendData;
        mPend = 1'b0;
        if (s && wr) begin
            mOpen = d;
            case (a)
                3'd0: begin mCtrl = d; mT = (mT & 15'h73FF) | (15'(d[1:0]) << 10); end
                3'd1: mMask = d;
                3'd3: mOamAddr = d;
                3'd4: begin mOam[mOamAddr] = d; mOamAddr = mOamAddr + 8'd1; end
                3'd5: begin
                    if (!mW) begin mT = (mT & 15'h7FE0) | 15'(d[7:3]); mFx = d[2:0]; end
                    else mT = (mT & 15'h0C1F) | (15'(d[2:0]) << 12) | (15'(d[7:3]) << 5);
                    mW = ~mW;
                end
                3'd6: begin
                    if (!mW) mT = (mT & 15'h00FF) | (15'(d[5:0]) << 8);
                    else begin mT = (mT & 15'h7F00) | 15'(d); mV = mT; end
                    mW = ~mW;
                end
                3'd7: begin mVram[mV[13:0]] = d; mV = mV + inc; end
                default: ;
            endcase
        end else if (s) begin
            if (a == 3'd2) mW = 1'b0;
            if (a == 3'd7) begin
                mPend = 1'b1;
                mPendData = mVram[mV[13:0]];
                mV = mV + inc;
            end
        end
        mVbl = vs ? 1'b1 : (vc ? 1'b0 : (statusRd ? 1'b0 : mVbl));
        mS0  = s0s ? 1'b1 : (vc ? 1'b0 : mS0);
        mOvf = os ? 1'b1 : (vc ? 1'b0 : mOvf);
    endtask

    task automatic busCycle(input logic s, input logic wr, input logic [2:0] a,
                            input logic [7:0] d, input logic vs, input logic vc,
                            input logic s0s, input logic os);
        logic [7:0] expRd;
        @(negedge cpuClk);
        check("ctrl", ctrl, mCtrl);
        check("mask", mask, mMask);
        check("v", v, mV);
        check("t", t, mT);
        check("fineX", fineX, mFx);
        check("oamAddr", oamAddr, mOamAddr);
        check("nmi", nmi, mVbl & mCtrl[7]);
        sel = s; wrEn = wr; addr = a; dataWr = d;
        vblankSet = vs; vblankClr = vc; sprite0HitSet = s0s; spriteOvfSet = os;
        #1;
        expRd = mOpen;
        if (s && !wr) begin
            case (a)
                3'd2:    expRd = {mVbl, mS0, mOvf, mOpen[4:0]};
                3'd4:    expRd = mOam[mOamAddr];
                3'd7:    expRd = mBuf;
                default: expRd = mOpen;
            endcase
        end
        check("dataRd", dataRd, expRd);
        check("vramAddr", vramAddr, mV[13:0]);
        check("oamWr", oamWr, s && wr && (a == 3'd4));
        check("vramWr", vramWr, s && wr && (a == 3'd7));
        check("vramRd", vramRd, s && !wr && (a == 3'd7));
        if (s && wr && (a == 3'd4)) check("oamWrData", oamWrData, d);
        if (s && wr && (a == 3'd7)) check("vramWrData", vramWrData, d);
        lastRd = dataRd; lastOamWr = oamWr; lastOamAddr = oamAddr;
        lastOamData = oamWrData; lastVramWr = vramWr; lastVramRd = vramRd;
        lastVramAddr = vramAddr; lastVramData = vramWrData;
        @(posedge cpuClk);
        modelStep(s, wr, a, d, vs, vc, s0s, os);
        #1;
    endtask

    task automatic wrReg(input logic [2:0] a, input logic [7:0] d);
        busCycle(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rdReg(input logic [2:0] a);
        busCycle(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        busCycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            envVram[i] = 8'(i * 7 + 3);
            mVram[i]   = 8'(i * 7 + 3);
        end
        envVram[14'h2000] = 8'h11; mVram[14'h2000] = 8'h11;
        envVram[14'h2020] = 8'h22; mVram[14'h2020] = 8'h22;
        for (int i = 0; i < 256; i++) begin
            envOam[i] = 8'(i) ^ 8'h5A;
            mOam[i]   = 8'(i) ^ 8'h5A;
        end
        modelReset();
        #12;
        @(negedge cpuClk);
        reset = 1'b1;

        // Reset state
        rdReg(3'd2);
        check("rst_status", lastRd, 8'h00);
        check("rst_nmi", nmi, 1'b0);
        check("rst_v", v, 15'h0000);
        check("rst_t", t, 15'h0000);

        // $2006 pair then a $2007 write
        wrReg(3'd6, 8'h21);
        wrReg(3'd6, 8'h08);
        check("addr_t", t, 15'h2108);
        check("addr_v", v, 15'h2108);
        wrReg(3'd7, 8'hAB);
        check("wr7_strobe", lastVramWr, 1'b1);
        check("wr7_addr", lastVramAddr, 14'h2108);
        check("wr7_data", lastVramData, 8'hAB);
        check("wr7_vinc", v, 15'h2109);

        // Buffered $2007 reads with increment 32
        wrReg(3'd0, 8'h04);
        wrReg(3'd6, 8'h20);
        wrReg(3'd6, 8'h00);
        check("rd7_vset", v, 15'h2000);
        rdReg(3'd7);
        check("rd7_first", lastRd, 8'h00);
        check("rd7_addr1", lastVramAddr, 14'h2000);
        idle();
        rdReg(3'd7);
        check("rd7_second", lastRd, 8'h11);
        check("rd7_addr2", lastVramAddr, 14'h2020);
        check("rd7_strobe", lastVramRd, 1'b1);
        idle();
        check("rd7_vfinal", v, 15'h2040);

        // $2005 pair, then a $2002 read resetting the toggle
        wrReg(3'd5, 8'h7D);
        wrReg(3'd5, 8'h5E);
        check("scr_fineX", fineX, 3'd5);
        check("scr_coarseX", t[4:0], 5'h0F);
        check("scr_coarseY", t[9:5], 5'h0B);
        check("scr_fineY", t[14:12], 3'd6);
        wrReg(3'd5, 8'h7D);
        rdReg(3'd2);
        wrReg(3'd5, 8'h5E);
        check("scr_w_fineX", fineX, 3'd6);
        check("scr_w_coarseX", t[4:0], 5'h0B);

        // vblank / NMI and flag priority
        wrReg(3'd0, 8'h80);
        busCycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("nmi_raise", nmi, 1'b1);
        rdReg(3'd2);
        check("stat_vbl", lastRd[7], 1'b1);
        check("nmi_clear", nmi, 1'b0);
        busCycle(1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("race_rd", lastRd[7], 1'b0);
        check("race_nmi", nmi, 1'b1);
        rdReg(3'd2);
        check("race_vbl", lastRd[7], 1'b1);

        // OAM address wrap and open bus
        wrReg(3'd3, 8'hFF);
        wrReg(3'd4, 8'h3C);
        check("oam_strobe", lastOamWr, 1'b1);
        check("oam_addr", lastOamAddr, 8'hFF);
        check("oam_data", lastOamData, 8'h3C);
        check("oam_wrap", oamAddr, 8'h00);
        wrReg(3'd1, 8'h9A);
        rdReg(3'd1);
        check("open_bus", lastRd, 8'h9A);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic s, wr, vs, vc, s0s, os;
            logic [2:0] a;
            logic [7:0] d;
            s   = ($urandom_range(0, 7) != 0);
            wr  = 1'($urandom_range(0, 1));
            a   = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            vs  = ($urandom_range(0, 15) == 0);
            vc  = ($urandom_range(0, 31) == 0);
            s0s = ($urandom_range(0, 15) == 0);
            os  = ($urandom_range(0, 15) == 0);
            busCycle(s, wr, a, d, vs, vc, s0s, os);

            // Reset while a fill is pending must drop the fill
            if (n == 750) begin
                rdReg(3'd7);
                reset = 1'b0;
                modelReset();
                #2;
                reset = 1'b1;
                rdReg(3'd7);
                check("rst_abort", lastRd, 8'h00);
            end
        end

        idle();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
